// File: rtl/kernel_kcore_start_bcast_fifo.sv
// Start-token broadcast FIFO: one producer, NUM_RD consumers.
// Each head token retires once every consumer has taken it.
module kernel_kcore_start_bcast_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_RD     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic [NUM_RD-1:0]     if_read,
  input  logic [NUM_RD-1:0]     if_read_ce,
  output logic [NUM_RD-1:0]     if_empty_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [NUM_RD-1:0] taken_q;
  logic [NUM_RD-1:0] taken_d;
  logic [NUM_RD-1:0] rd_acc;
  logic              full_q;
  logic              wr_acc;
  logic              retire;
  logic              nonempty;

  // Full is held active-high so every register powers up at its reset value.
  assign if_full_n  = ~full_q;
  assign count      = cnt_q;
  assign nonempty   = |cnt_q;
  assign if_empty_n = {NUM_RD{nonempty}} & ~taken_q;

  assign wr_acc = if_write & if_write_ce & ~full_q;
  assign rd_acc = if_read & if_read_ce & if_empty_n;
  assign retire = nonempty & (&(taken_q | rd_acc));

  always_comb begin
    cnt_d   = cnt_q;
    taken_d = taken_q | rd_acc;
    if (retire) begin
      taken_d = '0;
    end
    if (wr_acc && !retire) begin
      cnt_d = cnt_q + CW'(1);
    end else if (retire && !wr_acc) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      taken_q <= '0;
      full_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
      full_q  <= (cnt_d == CW'(DEPTH));
    end
  end

  // Shift register: newest at entry 0, head at entry count-1.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem[0] <= if_din;
      for (int k = 1; k < DEPTH; k++) begin
        mem[k] <= mem[k-1];
      end
    end
  end

  always_comb begin
    if_dout = mem[0];
    for (int k = 1; k < DEPTH; k++) begin
      if (cnt_q == CW'(k + 1)) begin
        if_dout = mem[k];
      end
    end
  end

endmodule

// File: tb/tb_kernel_kcore_start_bcast_fifo.sv
// Directed vector table plus a randomized fill/drain sequence
// on a non-power-of-two depth instance.
module tb_kernel_kcore_start_bcast_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: DEPTH=3, two consumers, byte tokens
  logic       a_reset, a_write, a_write_ce, a_full_n;
  logic [7:0] a_din, a_dout;
  logic [1:0] a_read, a_read_ce, a_empty_n;
  logic [2:0] a_count;

  kernel_kcore_start_bcast_fifo #(
    .DATA_WIDTH(8), .DEPTH(3), .ADDR_WIDTH(2), .NUM_RD(2)
  ) dut_a (
    .clk(clk), .reset(a_reset),
    .if_write(a_write), .if_write_ce(a_write_ce),
    .if_din(a_din), .if_full_n(a_full_n),
    .if_read(a_read), .if_read_ce(a_read_ce),
    .if_empty_n(a_empty_n), .if_dout(a_dout),
    .count(a_count)
  );

  // Instance B: DEPTH=5, ADDR_WIDTH=3
  logic       b_reset, b_write, b_write_ce, b_full_n;
  logic [7:0] b_din, b_dout;
  logic [1:0] b_read, b_read_ce, b_empty_n;
  logic [3:0] b_count;

  kernel_kcore_start_bcast_fifo #(
    .DATA_WIDTH(8), .DEPTH(5), .ADDR_WIDTH(3), .NUM_RD(2)
  ) dut_b (
    .clk(clk), .reset(b_reset),
    .if_write(b_write), .if_write_ce(b_write_ce),
    .if_din(b_din), .if_full_n(b_full_n),
    .if_read(b_read), .if_read_ce(b_read_ce),
    .if_empty_n(b_empty_n), .if_dout(b_dout),
    .count(b_count)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic       wce;
    logic [7:0] din;
    logic [1:0] rd;
    logic [1:0] rce;
    logic [2:0] cnt;
    logic [1:0] en;
    logic       fn;
    logic       chkd;
    logic [7:0] dout;
  } vec_t;

  function automatic vec_t v(
    logic rst, logic wr, logic wce, logic [7:0] din,
    logic [1:0] rd, logic [1:0] rce,
    logic [2:0] cnt, logic [1:0] en, logic fn,
    logic chkd, logic [7:0] dout);
    vec_t r;
    r.rst = rst; r.wr = wr; r.wce = wce; r.din = din;
    r.rd = rd; r.rce = rce; r.cnt = cnt; r.en = en;
    r.fn = fn; r.chkd = chkd; r.dout = dout;
    return r;
  endfunction

  task automatic chk(string name, int idx,
                     logic [31:0] act, logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h",
               name, idx, act, exp);
    end
  endtask

  localparam int NV = 26;
  vec_t vecs [NV];

  // Model state for instance B
  int         mq[$];
  logic [1:0] mtaken;
  int         next_tok;
  int         exp_tok;
  logic       acc_w;
  logic [1:0] acc_r;
  logic       m_retire;
  int         cyc;

  initial begin
    vecs[0]  = v(1,0,1,8'h00,2'b00,2'b11, 0,2'b00,1,0,8'h00);
    vecs[1]  = v(0,1,1,8'h01,2'b00,2'b11, 1,2'b11,1,1,8'h01);
    vecs[2]  = v(0,0,1,8'h00,2'b01,2'b11, 1,2'b10,1,1,8'h01);
    vecs[3]  = v(0,0,1,8'h00,2'b10,2'b11, 0,2'b00,1,0,8'h00);
    vecs[4]  = v(0,1,0,8'h77,2'b00,2'b11, 0,2'b00,1,0,8'h00);
    vecs[5]  = v(0,1,1,8'h01,2'b00,2'b11, 1,2'b11,1,1,8'h01);
    vecs[6]  = v(0,1,1,8'h02,2'b00,2'b11, 2,2'b11,1,1,8'h01);
    vecs[7]  = v(0,1,1,8'h03,2'b00,2'b11, 3,2'b11,0,1,8'h01);
    vecs[8]  = v(0,1,1,8'h04,2'b00,2'b11, 3,2'b11,0,1,8'h01);
    vecs[9]  = v(0,0,1,8'h00,2'b11,2'b01, 3,2'b10,0,1,8'h01);
    vecs[10] = v(0,1,1,8'h05,2'b10,2'b11, 2,2'b11,1,1,8'h02);
    vecs[11] = v(0,0,1,8'h00,2'b11,2'b11, 1,2'b11,1,1,8'h03);
    vecs[12] = v(0,0,1,8'h00,2'b11,2'b11, 0,2'b00,1,0,8'h00);
    vecs[13] = v(0,1,1,8'h0A,2'b00,2'b11, 1,2'b11,1,1,8'h0A);
    vecs[14] = v(0,1,1,8'h0B,2'b00,2'b11, 2,2'b11,1,1,8'h0A);
    vecs[15] = v(0,0,1,8'h00,2'b01,2'b11, 2,2'b10,1,1,8'h0A);
    vecs[16] = v(0,0,1,8'h00,2'b01,2'b11, 2,2'b10,1,1,8'h0A);
    vecs[17] = v(0,1,1,8'h0C,2'b10,2'b11, 2,2'b11,1,1,8'h0B);
    vecs[18] = v(0,0,1,8'h00,2'b11,2'b11, 1,2'b11,1,1,8'h0C);
    vecs[19] = v(0,0,1,8'h00,2'b11,2'b11, 0,2'b00,1,0,8'h00);
    vecs[20] = v(0,1,1,8'h0D,2'b00,2'b11, 1,2'b11,1,1,8'h0D);
    vecs[21] = v(0,1,1,8'h0E,2'b00,2'b11, 2,2'b11,1,1,8'h0D);
    vecs[22] = v(0,0,1,8'h00,2'b10,2'b11, 2,2'b01,1,1,8'h0D);
    vecs[23] = v(1,1,1,8'h0F,2'b11,2'b11, 0,2'b00,1,0,8'h00);
    vecs[24] = v(0,1,1,8'h05,2'b00,2'b11, 1,2'b11,1,1,8'h05);
    vecs[25] = v(0,0,1,8'h00,2'b11,2'b11, 0,2'b00,1,0,8'h00);

    a_reset = 1'b1; a_write = 1'b0; a_write_ce = 1'b0;
    a_din = '0; a_read = '0; a_read_ce = '0;
    b_reset = 1'b1; b_write = 1'b0; b_write_ce = 1'b0;
    b_din = '0; b_read = '0; b_read_ce = '0;

    // Directed table on instance A
    for (int i = 0; i < NV; i++) begin
      a_reset    = vecs[i].rst;
      a_write    = vecs[i].wr;
      a_write_ce = vecs[i].wce;
      a_din      = vecs[i].din;
      a_read     = vecs[i].rd;
      a_read_ce  = vecs[i].rce;
      @(posedge clk);
      #1;
      chk("count", i, 32'(a_count), 32'(vecs[i].cnt));
      chk("empty_n", i, 32'(a_empty_n), 32'(vecs[i].en));
      chk("full_n", i, 32'(a_full_n), 32'(vecs[i].fn));
      if (vecs[i].chkd)
        chk("dout", i, 32'(a_dout), 32'(vecs[i].dout));
    end
    a_write = 1'b0; a_read = '0;

    // Random fill/drain on instance B
    @(posedge clk);
    #1;
    b_reset = 1'b0;
    chk("b_reset_count", 0, 32'(b_count), 32'd0);
    chk("b_reset_full_n", 0, 32'(b_full_n), 32'd1);
    mtaken = '0;
    next_tok = 1;
    exp_tok = 1;
    cyc = 0;
    while (exp_tok <= 40 && cyc < 3000) begin
      cyc++;
      b_write    = (next_tok <= 40) && ($urandom_range(0, 3) != 0);
      b_write_ce = ($urandom_range(0, 3) != 0);
      b_din      = 8'(next_tok);
      // Bias toward fill phases and drain phases
      if (cyc % 200 < 100) begin
        b_read    = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      end else begin
        b_read    = 2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3));
      end
      b_read_ce = 2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3));
      acc_w = b_write & b_write_ce & (mq.size() < 5);
      acc_r = b_read & b_read_ce & ~mtaken &
              {2{mq.size() != 0}};
      m_retire = (mq.size() != 0) && ((mtaken | acc_r) == 2'b11);
      @(posedge clk);
      #1;
      if (m_retire) begin
        chk("b_order", exp_tok, 32'(mq[0]), 32'(exp_tok));
        void'(mq.pop_front());
        exp_tok++;
        mtaken = '0;
      end else begin
        mtaken = mtaken | acc_r;
      end
      if (acc_w) begin
        mq.push_back(next_tok);
        next_tok++;
      end
      chk("b_count", cyc, 32'(b_count), 32'(mq.size()));
      if (b_count > 4'd5) begin
        n_assert++;
        n_fail++;
        $display("FAIL b_count_max[%0d]: got %0d required <= 5",
                 cyc, b_count);
      end
      chk("b_empty_n", cyc, 32'(b_empty_n),
          32'({2{mq.size() != 0}} & ~mtaken));
      chk("b_full_n", cyc, 32'(b_full_n), 32'(mq.size() != 5));
      if (mq.size() != 0)
        chk("b_dout", cyc, 32'(b_dout), 32'(mq[0]));
    end
    if (exp_tok <= 40) begin
      n_assert++;
      n_fail++;
      $display("FAIL b_drain_timeout: got %0d tokens retired required 40",
               exp_tok - 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
